tx_frame_shaper: RTL

TX_FRAME_SHAPER -- requirements
Module: tx_frame_shaper

---
 rtl/tx_frame_shaper_pkg.sv | 21 ++
 rtl/tx_frame_shaper.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_shaper_pkg.sv
// ---------------------------------------------------------------------------
// eth_defs
// Shared Ethernet framing definitions for the TX frame shaper.
//   ETH_MIN_FRAME  : minimum frame length toward the MAC, FCS excluded
//   ETH_MAX_FRAME  : maximum frame length toward the MAC, FCS excluded
//   ETH_CNT_W      : width of the per-frame byte counter
//   shaper_state_t : shaper FSM state encodings (PASS / PAD / DROP)
// ---------------------------------------------------------------------------
package eth_defs;

    localparam int ETH_MIN_FRAME = 60;
    localparam int ETH_MAX_FRAME = 1514;
    localparam int ETH_CNT_W     = 11;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        PAD  = 2'd1,
        DROP = 2'd2
    } shaper_state_t;

endpackage

// File: rtl/tx_frame_shaper.sv
// ---------------------------------------------------------------------------
// tx_frame_shaper
// Sits between an upstream byte stream and the MAC transmit interface.
// Short frames are padded with 0x00 up to MIN_FRAME bytes, frames that reach
// MAX_FRAME bytes without a last beat are cut and flagged bad, and the rest
// of an over-length frame is swallowed. A single output register stage
// decouples the MAC handshake from upstream.
//
// Ports
//   clk            : MAC transmit clock, rising edge
//   reset          : asynchronous, active-low
//   in_valid       : upstream byte valid
//   in_data[7:0]   : upstream byte
//   in_last        : final upstream byte of the frame
//   in_err         : upstream error flag, sampled on every accepted beat
//   in_ready       : upstream beat is accepted this cycle
//   tx_mac_valid   : byte valid toward the MAC
//   tx_mac_data    : byte toward the MAC
//   tx_mac_last    : final byte of the frame toward the MAC
//   tx_mac_err     : frame is bad, only ever set together with tx_mac_last
//   tx_mac_ready   : MAC accepts the output beat
//   frame_done     : one-cycle pulse when a last beat enters the output reg
//   pad_count      : wrapping count of padded frames
//   trunc_count    : wrapping count of truncated frames
//
// state | meaning
// ------+--------------------------------------------------------------
// PASS  | forward upstream bytes, count them, track sticky error
// PAD   | upstream stalled, emit 0x00 until the frame reaches MIN_FRAME
// DROP  | frame was cut at MAX_FRAME, discard beats up to its in_last
// ---------------------------------------------------------------------------
module tx_frame_shaper
    import eth_defs::*;
#(
    parameter int MIN_FRAME = ETH_MIN_FRAME,
    parameter int MAX_FRAME = ETH_MAX_FRAME
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_err,
    output logic        in_ready,
    output logic        tx_mac_valid,
    output logic [7:0]  tx_mac_data,
    output logic        tx_mac_last,
    output logic        tx_mac_err,
    input  logic        tx_mac_ready,
    output logic        frame_done,
    output logic [15:0] pad_count,
    output logic [15:0] trunc_count
);

    // Frame-length limits compared against cnt+1, so one extra bit of
    // headroom keeps the increment from wrapping.
    localparam logic [ETH_CNT_W:0] MIN_L = (ETH_CNT_W+1)'(MIN_FRAME);
    localparam logic [ETH_CNT_W:0] MAX_L = (ETH_CNT_W+1)'(MAX_FRAME);

    shaper_state_t          r_state;
    shaper_state_t          w_next_state;
    logic [ETH_CNT_W-1:0]   r_cnt;
    logic [ETH_CNT_W-1:0]   w_cnt_next;
    logic [ETH_CNT_W:0]     w_cnt_inc;
    logic                   r_err_acc;
    logic                   w_err_acc_next;

    logic                   r_valid;
    logic [7:0]             r_data;
    logic                   r_last;
    logic                   r_err;
    logic                   r_frame_done;
    logic [15:0]            r_pad_count;
    logic [15:0]            r_trunc_count;

    logic                   w_advance;
    logic                   w_load;
    logic [7:0]             w_ld_data;
    logic                   w_ld_last;
    logic                   w_ld_err;
    logic                   w_done;
    logic                   w_pad_inc;
    logic                   w_trunc_inc;
    logic                   w_in_ready;

    // The output register may take a new beat whenever it is empty or the
    // MAC is consuming the current one.
    assign w_advance = !r_valid || tx_mac_ready;
    assign w_cnt_inc = {1'b0, r_cnt} + {{ETH_CNT_W{1'b0}}, 1'b1};

    // -----------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= PASS;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_err_acc <= w_err_acc_next;
        end
    end

    // -----------------------------------------------------------------
    // FSM next state, output-register load and counter strobes
    // -----------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_err_acc_next = r_err_acc;
        w_load         = 1'b0;
        w_ld_data      = 8'h00;
        w_ld_last      = 1'b0;
        w_ld_err       = 1'b0;
        w_done         = 1'b0;
        w_pad_inc      = 1'b0;
        w_trunc_inc    = 1'b0;
        w_in_ready     = 1'b0;

        case (r_state)
            PASS: begin
                w_in_ready = w_advance;
                if (in_valid && w_advance) begin
                    w_load         = 1'b1;
                    w_ld_data      = in_data;
                    w_cnt_next     = w_cnt_inc[ETH_CNT_W-1:0];
                    w_err_acc_next = r_err_acc | in_err;
                    if (in_last) begin
                        if (w_cnt_inc >= MIN_L) begin
                            w_ld_last      = 1'b1;
                            w_ld_err       = r_err_acc | in_err;
                            w_done         = 1'b1;
                            w_cnt_next     = '0;
                            w_err_acc_next = 1'b0;
                        end else begin
                            // Short frame: last is withheld until the pad
                            // bytes have been emitted.
                            w_next_state = PAD;
                        end
                    end else if (w_cnt_inc == MAX_L) begin
                        // An in_last on this same byte took the branch above,
                        // so only a genuinely over-length frame lands here.
                        w_ld_last      = 1'b1;
                        w_ld_err       = 1'b1;
                        w_done         = 1'b1;
                        w_trunc_inc    = 1'b1;
                        w_cnt_next     = '0;
                        w_err_acc_next = 1'b0;
                        w_next_state   = DROP;
                    end
                end
            end

            PAD: begin
                if (w_advance) begin
                    w_load     = 1'b1;
                    w_ld_data  = 8'h00;
                    w_cnt_next = w_cnt_inc[ETH_CNT_W-1:0];
                    if (w_cnt_inc == MIN_L) begin
                        w_ld_last      = 1'b1;
                        w_ld_err       = r_err_acc;
                        w_done         = 1'b1;
                        w_pad_inc      = 1'b1;
                        w_cnt_next     = '0;
                        w_err_acc_next = 1'b0;
                        w_next_state   = PASS;
                    end
                end
            end

            DROP: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_next_state = PASS;
                end
            end

            default: begin
                w_next_state   = PASS;
                w_cnt_next     = '0;
                w_err_acc_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // Output register stage and statistics
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid       <= 1'b0;
            r_data        <= 8'h00;
            r_last        <= 1'b0;
            r_err         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_pad_count   <= 16'h0000;
            r_trunc_count <= 16'h0000;
        end else begin
            if (w_advance) begin
                r_valid <= w_load;
                if (w_load) begin
                    r_data <= w_ld_data;
                    r_last <= w_ld_last;
                    r_err  <= w_ld_err;
                end
            end
            r_frame_done <= w_done;
            if (w_pad_inc) begin
                r_pad_count <= r_pad_count + 16'd1;
            end
            if (w_trunc_inc) begin
                r_trunc_count <= r_trunc_count + 16'd1;
            end
        end
    end

    // in_ready is combinational from the MAC handshake; gating with reset
    // keeps it low for the whole time reset is held.
    assign in_ready     = w_in_ready & reset;
    assign tx_mac_valid = r_valid;
    assign tx_mac_data  = r_data;
    assign tx_mac_last  = r_last;
    assign tx_mac_err   = r_err;
    assign frame_done   = r_frame_done;
    assign pad_count    = r_pad_count;
    assign trunc_count  = r_trunc_count;

endmodule
